// File: rtl/seg_scan_sched.sv
// Scan scheduler for an 8-digit common-anode 7-segment panel with shadow/active digit tables.
// Latency: all outputs registered; shadow writes land next edge, active bank only at frame-end commit.
// Backpressure: none; commit_req is held by the requester until commit_ack, issued only at a frame boundary.
module seg_scan_sched #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [5:0] wr_data,
    input  logic       commit_req,
    output logic       commit_ack,
    input  logic [1:0] bright,
    output logic       frame_start,
    output logic [7:0] led_en,
    output logic [7:0] led_seg
);
    localparam int            CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [31:0]   BLANK_LEN = 32'(BLANK_CYC);
    localparam logic [31:0]   ON_MAX    = 32'(SCAN_DIV - BLANK_CYC);
    localparam logic [5:0]    ENTRY_OFF = 6'b010000;

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_ON,
        ST_OFF
    } state_t;

    logic          run_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    digit_q, digit_d;
    logic [1:0]    bright_q, bright_d;
    state_t        state_q, state_d;
    logic [5:0]    shadow_q [8];
    logic [5:0]    active_q [8];
    logic [7:0]    led_en_q, led_en_d;
    logic [7:0]    led_seg_q, led_seg_d;
    logic          frame_start_q, frame_start_d;
    logic          commit_ack_q;
    logic          commit_fire;
    logic [31:0]   on_len, on_end, cnt_ext;
    logic [5:0]    entry;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits.
    function automatic logic [6:0] font7(input logic [3:0] hex);
        case (hex)
            4'h0: font7 = 7'h40;
            4'h1: font7 = 7'h79;
            4'h2: font7 = 7'h24;
            4'h3: font7 = 7'h30;
            4'h4: font7 = 7'h19;
            4'h5: font7 = 7'h12;
            4'h6: font7 = 7'h02;
            4'h7: font7 = 7'h78;
            4'h8: font7 = 7'h00;
            4'h9: font7 = 7'h10;
            4'hA: font7 = 7'h08;
            4'hB: font7 = 7'h03;
            4'hC: font7 = 7'h46;
            4'hD: font7 = 7'h21;
            4'hE: font7 = 7'h06;
            default: font7 = 7'h0E;
        endcase
    endfunction

    // Slot position: held at 0 until the first edge after reset, then counts and steps digits.
    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        if (run_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                digit_d = digit_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Brightness is captured only during the first cycle of a slot; derive that slot's ON length.
    always_comb begin
        bright_d = (cnt_q == '0) ? bright : bright_q;
        on_len   = (ON_MAX * ({30'd0, bright_d} + 32'd1)) >> 2;
        if (on_len == 32'd0) begin
            on_len = 32'd1;
        end
        on_end = BLANK_LEN + on_len;
    end

    // Slot FSM and output decode, evaluated for the position the outputs will show next cycle.
    always_comb begin
        state_d       = state_q;
        cnt_ext       = 32'(cnt_d);
        led_en_d      = 8'hFF;
        led_seg_d     = 8'hFF;
        entry         = active_q[digit_d];
        frame_start_d = (cnt_d == '0) && (digit_d == 3'd0);
        commit_fire   = run_q && (cnt_q == CNT_LAST) && (digit_q == 3'd7) && commit_req;
        case (state_q)
            ST_BLANK: if (cnt_ext == BLANK_LEN) state_d = ST_ON;
            ST_ON: begin
                if (cnt_d == '0) begin
                    state_d = ST_BLANK;
                end else if (cnt_ext == on_end) begin
                    // Never reached at full brightness: on_end equals SCAN_DIV.
                    state_d = ST_OFF;
                end
            end
            ST_OFF:   if (cnt_d == '0) state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase
        if (state_d == ST_ON && !entry[4]) begin
            led_en_d  = ~(8'd1 << digit_d);
            led_seg_d = {~entry[5], font7(entry[3:0])};
        end
    end

    // Position, FSM state and registered panel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q         <= 1'b0;
            cnt_q         <= '0;
            digit_q       <= 3'd0;
            bright_q      <= 2'd0;
            state_q       <= ST_BLANK;
            led_en_q      <= 8'hFF;
            led_seg_q     <= 8'hFF;
            frame_start_q <= 1'b0;
            commit_ack_q  <= 1'b0;
        end else begin
            run_q         <= 1'b1;
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            bright_q      <= bright_d;
            state_q       <= state_d;
            led_en_q      <= led_en_d;
            led_seg_q     <= led_seg_d;
            frame_start_q <= frame_start_d;
            commit_ack_q  <= commit_fire;
        end
    end

    // Digit tables: producers write shadow; commit copies the pre-write shadow into active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= ENTRY_OFF;
                active_q[i] <= ENTRY_OFF;
            end
        end else begin
            if (commit_fire) begin
                for (int i = 0; i < 8; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (wr_en) begin
                shadow_q[wr_addr] <= wr_data;
            end
        end
    end

    assign led_en      = led_en_q;
    assign led_seg     = led_seg_q;
    assign frame_start = frame_start_q;
    assign commit_ack  = commit_ack_q;

endmodule

// File: tb/tb_seg_scan_sched.sv
module tb_seg_scan_sched;
    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       wr_en      = 1'b0;
    logic [2:0] wr_addr    = 3'd0;
    logic [5:0] wr_data    = 6'd0;
    logic       commit_req = 1'b0;
    logic [1:0] bright     = 2'd3;
    logic       commit_ack;
    logic       frame_start;
    logic [7:0] led_en;
    logic [7:0] led_seg;

    int n_checks = 0;
    int n_pass   = 0;
    int tb_cnt   = -1;
    int tb_digit = 0;
    int last_lit = -1;
    int off_run  = 0;

    logic [7:0] font_tb [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_scan_sched #(.SCAN_DIV(16), .BLANK_CYC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit_req  (commit_req),
        .commit_ack  (commit_ack),
        .bright      (bright),
        .frame_start (frame_start),
        .led_en      (led_en),
        .led_seg     (led_seg)
    );

    always #5 clk = ~clk;

    // One clock; track slot position and check the per-cycle panel invariants.
    task automatic tick();
        int lit;
        bit fs_exp;
        @(posedge clk);
        #1;
        if (!rst_n) tb_cnt = -1;
        else if (tb_cnt < 0) begin tb_cnt = 0; tb_digit = 0; end
        else if (tb_cnt == 15) begin tb_cnt = 0; tb_digit = (tb_digit + 1) % 8; end
        else tb_cnt++;
        fs_exp = (tb_cnt == 0 && tb_digit == 0);
        n_checks++;
        if (frame_start !== fs_exp)
            $display("FAIL frame_start d%0d c%0d: got %b want %b", tb_digit, tb_cnt, frame_start, fs_exp);
        else n_pass++;
        n_checks++;
        if ($countones(~led_en) > 1) $display("FAIL one_digit: led_en=%h want at most one low bit", led_en);
        else n_pass++;
        if (led_en === 8'hFF) begin
            off_run++;
        end else begin
            lit = -1;
            for (int i = 0; i < 8; i++) if (!led_en[i] && lit < 0) lit = i;
            if (last_lit >= 0 && lit != last_lit) begin
                n_checks++;
                if (off_run < 4) $display("FAIL blank_gap %0d->%0d: got %0d off cycles want >=4", last_lit, lit, off_run);
                else n_pass++;
            end
            last_lit = lit;
            off_run  = 0;
        end
    endtask

    task automatic run_to(input int d, input int c);
        int n = 0;
        do begin tick(); n++; end while (!(tb_digit == d && tb_cnt == c) && n < 200);
        if (!(tb_digit == d && tb_cnt == c)) begin
            n_checks++;
            $display("FAIL run_to d%0d c%0d: not reached in %0d cycles", d, c, n);
        end
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [5:0] v);
        wr_en = 1'b1; wr_addr = a; wr_data = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_commit(input string tag);
        run_to(7, 14);
        commit_req = 1'b1;
        tick();
        n_checks++; if (commit_ack !== 1'b0) $display("FAIL %s ack_early: got %b want 0", tag, commit_ack); else n_pass++;
        tick();
        n_checks++; if (commit_ack !== 1'b1) $display("FAIL %s ack: got %b want 1", tag, commit_ack); else n_pass++;
        commit_req = 1'b0;
        tick();
        n_checks++; if (commit_ack !== 1'b0) $display("FAIL %s ack_drop: got %b want 0", tag, commit_ack); else n_pass++;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        tick(); tick();
        n_checks++; if (led_en !== 8'hFF) $display("FAIL rst led_en: got %h want ff", led_en); else n_pass++;
        n_checks++; if (led_seg !== 8'hFF) $display("FAIL rst led_seg: got %h want ff", led_seg); else n_pass++;
        n_checks++; if (commit_ack !== 1'b0) $display("FAIL rst ack: got %b want 0", commit_ack); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if (frame_start !== 1'b1) $display("FAIL first_frame_start: got %b want 1", frame_start); else n_pass++;
        n_checks++; if (led_en !== 8'hFF) $display("FAIL first_cycle led_en: got %h want ff", led_en); else n_pass++;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 130; i++) begin
            tick();
            n_checks++; if (led_en !== 8'hFF) $display("FAIL idle led_en cyc %0d: got %h want ff", i, led_en); else n_pass++;
            n_checks++; if (commit_ack !== 1'b0) $display("FAIL idle ack cyc %0d: got %b want 0", i, commit_ack); else n_pass++;
        end
    endtask

    task automatic test_commit();
        for (int k = 0; k < 8; k++) write_entry(3'(k), 6'(k));
        do_commit("commit1");
        for (int k = 0; k < 8; k++) begin
            run_to(k, 3);
            n_checks++; if (led_en !== 8'hFF) $display("FAIL d%0d blank c3: got %h want ff", k, led_en); else n_pass++;
            tick();
            n_checks++; if (led_en !== ~(8'd1 << k)) $display("FAIL d%0d en c4: got %h want %h", k, led_en, ~(8'd1 << k)); else n_pass++;
            n_checks++; if (led_seg !== font_tb[k]) $display("FAIL d%0d seg c4: got %h want %h", k, led_seg, font_tb[k]); else n_pass++;
            run_to(k, 15);
            n_checks++; if (led_en !== ~(8'd1 << k)) $display("FAIL d%0d en c15: got %h want %h", k, led_en, ~(8'd1 << k)); else n_pass++;
        end
    endtask

    task automatic test_bright();
        run_to(1, 15); bright = 2'd0;
        run_to(2, 6);
        n_checks++; if (led_en !== 8'hFB) $display("FAIL b0 c6: got %h want fb", led_en); else n_pass++;
        tick();
        n_checks++; if (led_en !== 8'hFF) $display("FAIL b0 c7: got %h want ff", led_en); else n_pass++;
        run_to(2, 15); bright = 2'd1;
        run_to(3, 9);
        n_checks++; if (led_en !== 8'hF7) $display("FAIL b1 c9: got %h want f7", led_en); else n_pass++;
        tick();
        n_checks++; if (led_en !== 8'hFF) $display("FAIL b1 c10: got %h want ff", led_en); else n_pass++;
        run_to(3, 15); bright = 2'd3;
        run_to(4, 6); bright = 2'd0;
        tick();
        n_checks++; if (led_en !== 8'hEF) $display("FAIL midslot c7: got %h want ef", led_en); else n_pass++;
        run_to(4, 15);
        n_checks++; if (led_en !== 8'hEF) $display("FAIL midslot c15: got %h want ef", led_en); else n_pass++;
        run_to(5, 6);
        n_checks++; if (led_en !== 8'hDF) $display("FAIL nextslot c6: got %h want df", led_en); else n_pass++;
        tick();
        n_checks++; if (led_en !== 8'hFF) $display("FAIL nextslot c7: got %h want ff", led_en); else n_pass++;
        bright = 2'd3;
    endtask

    task automatic test_shadow();
        write_entry(3'd2, 6'h2A);
        run_to(2, 5);
        n_checks++; if (led_seg !== 8'hA4) $display("FAIL shadow_only seg: got %h want a4", led_seg); else n_pass++;
        do_commit("commit_dp");
        run_to(2, 5);
        n_checks++; if (led_seg !== 8'h08) $display("FAIL dp_A seg: got %h want 08", led_seg); else n_pass++;
        n_checks++; if (led_en !== 8'hFB) $display("FAIL dp_A en: got %h want fb", led_en); else n_pass++;
    endtask

    task automatic test_back_to_back();
        write_entry(3'd5, 6'h10);
        do_commit("commit_blank");
        run_to(5, 8);
        n_checks++; if (led_en !== 8'hFF) $display("FAIL blank_entry en: got %h want ff", led_en); else n_pass++;
        n_checks++; if (led_seg !== 8'hFF) $display("FAIL blank_entry seg: got %h want ff", led_seg); else n_pass++;
        run_to(7, 14); commit_req = 1'b1;
        tick();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 6'h03;
        tick();
        n_checks++; if (commit_ack !== 1'b1) $display("FAIL same_cycle ack: got %b want 1", commit_ack); else n_pass++;
        wr_en = 1'b0; commit_req = 1'b0;
        run_to(5, 8);
        n_checks++; if (led_en !== 8'hFF) $display("FAIL same_cycle not_yet: got %h want ff", led_en); else n_pass++;
        do_commit("commit_late");
        run_to(5, 8);
        n_checks++; if (led_en !== 8'hDF) $display("FAIL late en: got %h want df", led_en); else n_pass++;
        n_checks++; if (led_seg !== 8'hB0) $display("FAIL late seg: got %h want b0", led_seg); else n_pass++;
    endtask

    task automatic test_reset_mid();
        run_to(3, 6);
        n_checks++; if (led_en !== 8'hF7) $display("FAIL pre_rst en: got %h want f7", led_en); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (led_en !== 8'hFF) $display("FAIL mid_rst en: got %h want ff", led_en); else n_pass++;
        n_checks++; if (led_seg !== 8'hFF) $display("FAIL mid_rst seg: got %h want ff", led_seg); else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (frame_start !== 1'b1) $display("FAIL post_rst frame_start: got %b want 1", frame_start); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            run_to(k, 8);
            n_checks++; if (led_en !== 8'hFF) $display("FAIL post_rst d%0d en: got %h want ff", k, led_en); else n_pass++;
        end
        do_commit("commit_after_rst");
        run_to(2, 8);
        n_checks++; if (led_en !== 8'hFF) $display("FAIL shadow_lost en: got %h want ff", led_en); else n_pass++;
        n_checks++; if (led_seg !== 8'hFF) $display("FAIL shadow_lost seg: got %h want ff", led_seg); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_commit();
        test_bright();
        test_shadow();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
